ppm_frame_tx: RTL and testbench
===============================

# ppm_frame_tx

Pulse-position-modulation (PPM) frame encoder: the transmit-side counterpart of the RF-receiver decoder that feeds the servo and ESC PWM generators. It serializes NUM_CH 8-bit channel values into a standard RC PPM pulse train on one output pin. Typical uses are driving an RF transmitter module or looping back into the receiver path for bench test. It runs from the 8 MHz board clock and uses a 1 µs tick derived internally.

## Interface
- TICK_DIV, 8, clock cycles per 1 µs tick (8 for iCLK = 8 MHz)
- NUM_CH, 4, channels per frame (1..8)
- SEP_US, 300, separator pulse width in µs
- FRAME_US, 20000, frame period in µs; must be ≥ NUM_CH*2020 + SEP_US + 3000
- iCLK  in  1  system clock; all logic on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iCH_DATA  in  NUM_CH*8  channel values; channel k = bits [8k+7:8k]
- iLOAD  in  1  one-cycle strobe; latches iCH_DATA into shadow registers
- iENABLE  in  1  level; frames are generated while high
- oPPM  out  1  PPM output, idle low, separator pulses high (registered)
- oFRAME_START  out  1  one-cycle pulse at the start of each frame (registered)
- oBUSY  out  1  high while a frame is in progress

## Operation
- Reset values: oPPM=0, oFRAME_START=0, oBUSY=0, state=IDLE, shadow and active registers=0, all counters=0.
- Channel interval: interval_k = 1000 + 4*v_k µs, range 1000..2020 µs. Computed as 1000 + {v,2'b00} with a 12-bit result and no overflow.
- Each channel slot: oPPM high for SEP_US, then low for interval_k − SEP_US. Slot length (rising edge to rising edge) is interval_k.
- After the last channel slot comes a closing separator pulse of SEP_US. oPPM then stays low until the frame counter reaches FRAME_US.
- Rising edges per frame: NUM_CH+1.
- Double buffering:
  - iLOAD writes the shadow registers.
  - At each frame start, active ← shadow.
  - If iLOAD coincides with the frame-start copy, active ← iCH_DATA (bypass).
  - Active values never change mid-frame.
- State machine:
  - IDLE: oPPM=0. If iENABLE=1, go to PULSE and start a frame.
  - PULSE: oPPM=1 for SEP_US ticks. Then go to GAP if ch_idx < NUM_CH, else go to SYNC.
  - GAP: oPPM=0 until slot µs count = interval_k. Then ch_idx++ and go to PULSE.
  - SYNC: oPPM=0 until frame µs count = FRAME_US. Then go to PULSE and start a new frame if iENABLE=1, else go to IDLE.
- Frame start (one clock edge):
  - oPPM←1, oFRAME_START←1, oBUSY←1, active copy.
  - Prescaler, slot counter, frame counter and ch_idx all ← 0.
- Counters:
  - Prescaler counts 0..TICK_DIV−1; the tick fires at TICK_DIV−1.
  - Slot counter is 12 bits.
  - Frame counter is $clog2(FRAME_US+1) bits.
  - No counter wraps within a frame.
- iENABLE falling mid-frame: the current frame completes in full, then the block goes to IDLE. No truncated frames.
- iRESET mid-frame: all registers return to reset values immediately (asynchronously), and oPPM drops to 0 in the same instant.

## Timing
- Latency: iENABLE sampled high in IDLE at edge N gives oPPM=1 and oFRAME_START=1 after edge N (one cycle).
- Separator pulse: exactly SEP_US*TICK_DIV cycles high.
- Channel slot: exactly interval_k*TICK_DIV cycles.
- Frame: exactly FRAME_US*TICK_DIV cycles. Back-to-back frames have no extra idle cycle.
- oFRAME_START is high for exactly one cycle per frame.
- oBUSY falls on the same edge that returns the state to IDLE.
- iLOAD data taken at edge M is used by the first frame starting at or after edge M.

## Test plan
- Defaults, iLOAD with values {0,255,128,64}, then iENABLE=1 → 5 high pulses of 2400 cycles each:
  - Slots of 8000, 16160, 12096 and 10048 cycles.
  - Closing gap of 13912 µs (111296 cycles) low.
  - Frame of 160000 cycles; oFRAME_START pulses every 160000 cycles.
- iLOAD of new values mid-frame (e.g. all 0xFF) → current frame unchanged. The next frame has four 16160-cycle slots.
- iLOAD on the exact frame-start cycle → that same frame uses the new values (bypass).
- iENABLE dropped 100 cycles after frame start → full frame emitted, then oPPM=0 and oBUSY=0 in IDLE. No second oFRAME_START.
- iRESET asserted during a PULSE → oPPM=0 and oBUSY=0 immediately. After release with iENABLE=1, a fresh frame starts using all-zero active values (1000 µs slots).
- NUM_CH=1, FRAME_US=6000, value 0x80 → per frame: one 1512 µs slot, closing pulse, low until 6000 µs. Exactly 2 rising edges per frame.

Source files
------------

// File: rtl/ppm_frame_tx.sv
// ppm_frame_tx: serializes NUM_CH 8-bit channel values into an RC PPM pulse
// train. Each channel slot is a SEP_US high separator followed by low time,
// with a slot length of 1000 + 4*value us. A closing separator follows the
// last slot, and the line then idles low until the frame period expires.
// Channel values are double buffered: iLOAD fills the shadow registers, and
// each frame start copies them (or iCH_DATA directly, when iLOAD coincides)
// into the active set.
module ppm_frame_tx #(
  parameter int TICK_DIV = 8,
  parameter int NUM_CH   = 4,
  parameter int SEP_US   = 300,
  parameter int FRAME_US = 20000
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic [NUM_CH*8-1:0]   iCH_DATA,
  input  logic                  iLOAD,
  input  logic                  iENABLE,
  output logic                  oPPM,
  output logic                  oFRAME_START,
  output logic                  oBUSY
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FRAME_US + 1);
  localparam int CW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, SYNC} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [PW-1:0]       r_presc;
  logic [11:0]         r_slotUs;
  logic [FW-1:0]       r_frameUs;
  logic [CW-1:0]       r_chIdx;
  logic [NUM_CH*8-1:0] r_shadow;
  logic [NUM_CH*8-1:0] r_active;
  logic                r_ppm;
  logic                r_frameStart;
  logic                r_busy;

  logic                w_tick;
  logic                w_startFrame;
  logic                w_sepDone;
  logic                w_slotDone;
  logic                w_frameDone;
  logic                w_countSlot;
  logic [7:0]          w_curVal;
  logic [11:0]         w_interval;
  logic                w_ppmNext;
  logic                w_frameStartNext;
  logic                w_busyNext;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Pick the active value of the channel whose slot is currently running.
  always_comb begin
    w_curVal = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_chIdx == CW'(i)) begin
        w_curVal = r_active[8*i +: 8];
      end
    end
  end

  // Slot length is 1000 + 4*v us; the maximum of 2020 fits 12 bits, so no overflow.
  assign w_interval  = 12'd1000 + {2'b00, w_curVal, 2'b00};
  assign w_sepDone   = w_tick && (r_slotUs == 12'(SEP_US - 1));
  assign w_slotDone  = w_tick && (r_slotUs == (w_interval - 12'd1));
  assign w_frameDone = w_tick && (r_frameUs == FW'(FRAME_US - 1));

  // The slot counter is frozen during SYNC so the long closing gap cannot wrap it.
  assign w_countSlot = (r_state == PULSE) || (r_state == GAP);

  // State register.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; also flags the edges on which a new frame begins.
  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    case (r_state)
      IDLE: begin
        if (iENABLE) begin
          w_nextState  = PULSE;
          w_startFrame = 1'b1;
        end
      end
      PULSE: begin
        if (w_sepDone) begin
          w_nextState = (r_chIdx < CW'(NUM_CH)) ? GAP : SYNC;
        end
      end
      GAP: begin
        if (w_slotDone) begin
          w_nextState = PULSE;
        end
      end
      SYNC: begin
        if (w_frameDone) begin
          if (iENABLE) begin
            w_nextState  = PULSE;
            w_startFrame = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the pins can be registered.
  always_comb begin
    w_ppmNext        = (w_nextState == PULSE);
    w_busyNext       = (w_nextState != IDLE);
    w_frameStartNext = w_startFrame;
  end

  // Timing counters, channel buffers and registered outputs.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_presc      <= '0;
      r_slotUs     <= '0;
      r_frameUs    <= '0;
      r_chIdx      <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_ppm        <= 1'b0;
      r_frameStart <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ppm        <= w_ppmNext;
      r_frameStart <= w_frameStartNext;
      r_busy       <= w_busyNext;

      if (iLOAD) begin
        r_shadow <= iCH_DATA;
      end

      if (w_startFrame) begin
        r_presc   <= '0;
        r_slotUs  <= '0;
        r_frameUs <= '0;
        r_chIdx   <= '0;
        r_active  <= iLOAD ? iCH_DATA : r_shadow;
      end else if (w_nextState == IDLE) begin
        r_presc   <= '0;
        r_slotUs  <= '0;
        r_frameUs <= '0;
        r_chIdx   <= '0;
      end else begin
        if (w_tick) begin
          r_presc   <= '0;
          r_frameUs <= r_frameUs + FW'(1);
          if (r_state == GAP && w_slotDone) begin
            r_slotUs <= '0;
          end else if (w_countSlot) begin
            r_slotUs <= r_slotUs + 12'd1;
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
        if (r_state == GAP && w_slotDone) begin
          r_chIdx <= r_chIdx + CW'(1);
        end
      end
    end
  end

  assign oPPM         = r_ppm;
  assign oFRAME_START = r_frameStart;
  assign oBUSY        = r_busy;

endmodule

// File: tb/tb_ppm_frame_tx.sv
// tb_ppm_frame_tx: directed bench for ppm_frame_tx. Instance A uses a fast
// tick (2 cycles/us), two channels, 20 us separators and a 7100 us frame.
// Instance B uses a single channel, a 6000 us frame and 1 cycle/us.
// Output phase lengths are compared against hand-computed cycle counts.
module tb_ppm_frame_tx;

  typedef struct {
    int    group;
    string name;
    logic  level;
    int    cycles;
  } phase_t;

  logic        clock = 1'b0;
  logic        resetA = 1'b1;
  logic        resetB = 1'b1;
  logic [15:0] chDataA = '0;
  logic        loadA = 1'b0;
  logic        enableA = 1'b0;
  logic        ppmA, frameStartA, busyA;
  logic [7:0]  chDataB = '0;
  logic        loadB = 1'b0;
  logic        enableB = 1'b0;
  logic        ppmB, frameStartB, busyB;

  logic        selB = 1'b0;
  logic        monPpm, monBusy;

  int          checkCnt = 0;
  int          passCnt = 0;
  phase_t      vectors[$];

  int          cyc = 0;
  int          fsCntA = 0, fsGapA = 0, lastFsA = 0, fsWideA = 0;
  logic        prevFsA = 1'b0;
  int          fsGapB = 0, lastFsB = 0, risesB = 0, lastFrameRisesB = 0;
  logic        prevPpmB = 1'b0;

  ppm_frame_tx #(.TICK_DIV(2), .NUM_CH(2), .SEP_US(20), .FRAME_US(7100)) dutA (
    .iCLK(clock), .iRESET(resetA), .iCH_DATA(chDataA), .iLOAD(loadA),
    .iENABLE(enableA), .oPPM(ppmA), .oFRAME_START(frameStartA), .oBUSY(busyA)
  );

  ppm_frame_tx #(.TICK_DIV(1), .NUM_CH(1), .SEP_US(300), .FRAME_US(6000)) dutB (
    .iCLK(clock), .iRESET(resetB), .iCH_DATA(chDataB), .iLOAD(loadB),
    .iENABLE(enableB), .oPPM(ppmB), .oFRAME_START(frameStartB), .oBUSY(busyB)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  assign monPpm  = selB ? ppmB : ppmA;
  assign monBusy = selB ? busyB : busyA;

  // Track frame-start spacing and width, and rising edges per frame on B.
  always @(negedge clock) begin
    cyc++;
    if (frameStartA === 1'b1) begin
      fsCntA++;
      fsGapA  = cyc - lastFsA;
      lastFsA = cyc;
      if (prevFsA === 1'b1) fsWideA++;
    end
    prevFsA = frameStartA;
    if (frameStartB === 1'b1) begin
      fsGapB          = cyc - lastFsB;
      lastFsB         = cyc;
      lastFrameRisesB = risesB;
      risesB          = 0;
    end
    if (ppmB === 1'b1 && prevPpmB !== 1'b1) risesB++;
    prevPpmB = ppmB;
  end

  // Hard stop in case something never terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached, checks so far %0d/%0d", passCnt, checkCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] data);
    enableA = en;
    loadA   = ld;
    chDataA = data;
  endtask

  task automatic addVec(input int g, input string n, input logic l, input int c);
    phase_t p;
    p.group  = g;
    p.name   = n;
    p.level  = l;
    p.cycles = c;
    vectors.push_back(p);
  endtask

  // Count consecutive negedge samples at the given level, starting with the current one.
  task automatic measureLevel(input logic level, output int cnt);
    cnt = 0;
    while (monPpm === level && cnt < 30000) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  task automatic measureBusy(output int cnt);
    cnt = 0;
    while (monBusy === 1'b1 && cnt < 30000) begin
      cnt++;
      @(negedge clock);
    end
  endtask

  task automatic runGroup(input int g);
    int cnt;
    for (int i = 0; i < vectors.size(); i++) begin
      if (vectors[i].group == g) begin
        measureLevel(vectors[i].level, cnt);
        checkOutput(vectors[i].name, cnt, vectors[i].cycles);
      end
    end
  endtask

  initial begin
    int cnt;

    // Group 0: A frame 1, values {ch0=0, ch1=255}: slots 2000 and 4040 cycles.
    addVec(0, "f1 sep0", 1'b1, 40);
    addVec(0, "f1 gap0", 1'b0, 1960);
    addVec(0, "f1 sep1", 1'b1, 40);
    addVec(0, "f1 gap1", 1'b0, 4000);
    addVec(0, "f1 close", 1'b1, 40);
    addVec(0, "f1 sync", 1'b0, 8120);
    // Group 1: A frame 2 after mid-frame load {ch0=128, ch1=64}: slots 3024, 2512.
    addVec(1, "f2 sep0", 1'b1, 40);
    addVec(1, "f2 gap0", 1'b0, 2984);
    addVec(1, "f2 sep1", 1'b1, 40);
    addVec(1, "f2 gap1", 1'b0, 2472);
    addVec(1, "f2 close", 1'b1, 40);
    // Group 2: bypass load {ch0=255, ch1=0} on the start edge: first slot 4040.
    addVec(2, "bypass sep0", 1'b1, 40);
    addVec(2, "bypass gap0", 1'b0, 4000);
    // Group 3: after reset, active values are zero: 2000-cycle slots.
    addVec(3, "rst sep0", 1'b1, 40);
    addVec(3, "rst gap0", 1'b0, 1960);
    addVec(3, "rst sep1", 1'b1, 40);
    addVec(3, "rst gap1", 1'b0, 1960);
    addVec(3, "rst close", 1'b1, 40);
    // Group 4: B, single channel 0x80: 1512 us slot, closing pulse, low to 6000 us.
    addVec(4, "B sep0", 1'b1, 300);
    addVec(4, "B gap0", 1'b0, 1212);
    addVec(4, "B close", 1'b1, 300);
    addVec(4, "B sync", 1'b0, 4188);

    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clock);
    checkOutput("reset ppm", int'(ppmA), 0);
    checkOutput("reset frameStart", int'(frameStartA), 0);
    checkOutput("reset busy", int'(busyA), 0);
    resetA = 1'b0;
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, 1'b1, {8'd255, 8'd0});
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, {8'd255, 8'd0});
    repeat (5) @(negedge clock);
    checkOutput("idle after load busy", int'(busyA), 0);
    checkOutput("idle after load ppm", int'(ppmA), 0);

    applyStimulus(1'b1, 1'b0, {8'd255, 8'd0});
    @(negedge clock);
    checkOutput("start latency ppm", int'(ppmA), 1);
    checkOutput("start latency frameStart", int'(frameStartA), 1);
    checkOutput("start latency busy", int'(busyA), 1);

    fork
      begin
        repeat (500) @(negedge clock);
        applyStimulus(1'b1, 1'b1, {8'd64, 8'd128});
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, {8'd64, 8'd128});
      end
    join_none
    runGroup(0);

    checkOutput("f2 frameStart", int'(frameStartA), 1);
    fork
      begin
        repeat (100) @(negedge clock);
        applyStimulus(1'b0, 1'b0, {8'd64, 8'd128});
      end
    join_none
    runGroup(1);
    measureBusy(cnt);
    checkOutput("f2 sync busy", cnt, 8624);
    checkOutput("idle ppm after drop", int'(ppmA), 0);
    repeat (300) @(negedge clock);
    checkOutput("frame start count", fsCntA, 2);
    checkOutput("frame period", fsGapA, 14200);
    checkOutput("frame start width", fsWideA, 0);
    checkOutput("idle busy after drop", int'(busyA), 0);

    applyStimulus(1'b1, 1'b1, {8'd0, 8'd255});
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, {8'd0, 8'd255});
    checkOutput("bypass start ppm", int'(ppmA), 1);
    runGroup(2);
    checkOutput("pulse before reset", int'(ppmA), 1);
    resetA = 1'b1;
    #1;
    checkOutput("async reset ppm", int'(ppmA), 0);
    checkOutput("async reset busy", int'(busyA), 0);
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    @(negedge clock);
    resetA = 1'b0;
    @(negedge clock);
    checkOutput("post reset start ppm", int'(ppmA), 1);
    checkOutput("post reset frameStart", int'(frameStartA), 1);
    runGroup(3);
    resetA = 1'b1;

    selB = 1'b1;
    @(negedge clock);
    resetB = 1'b0;
    @(negedge clock);
    chDataB = 8'h80;
    loadB   = 1'b1;
    @(negedge clock);
    loadB   = 1'b0;
    enableB = 1'b1;
    @(negedge clock);
    checkOutput("B start ppm", int'(ppmB), 1);
    runGroup(4);
    checkOutput("B f2 frameStart", int'(frameStartB), 1);
    enableB = 1'b0;
    measureBusy(cnt);
    checkOutput("B f2 busy length", cnt, 6000);
    checkOutput("B frame period", fsGapB, 6000);
    checkOutput("B f1 rising edges", lastFrameRisesB, 2);
    checkOutput("B idle ppm", int'(ppmB), 0);
    repeat (20) @(negedge clock);
    checkOutput("B f2 rising edges", risesB, 2);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
